// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : systolic_pkg                                                 |
// | Description : Shared constants for the systolic array and its pool stage.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package systolic_pkg;

    // Cycle count from feed start until the 2x2 array outputs are final.
    localparam int DEFAULT_SETTLE_CYCLES = 18;

    typedef logic [1:0] pool_state_t;
    localparam pool_state_t ST_IDLE = 2'd0;
    localparam pool_state_t ST_WAIT = 2'd1;
    localparam pool_state_t ST_POOL = 2'd2;
    localparam pool_state_t ST_PUSH = 2'd3;

    localparam logic [1:0] IDX_11 = 2'd0;
    localparam logic [1:0] IDX_12 = 2'd1;
    localparam logic [1:0] IDX_21 = 2'd2;
    localparam logic [1:0] IDX_22 = 2'd3;

    localparam int ENTRY_W = 10;

    function automatic logic [7:0] relu8(input logic [7:0] v);
        return v[7] ? 8'd0 : v;
    endfunction

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/pool_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pool_fifo                                                    |
// | Description : Synchronous FIFO; a pop frees a slot for a same-cycle push.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pool_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

    logic [c_addr_w:0]  r_wr_ptr;
    logic [c_addr_w:0]  r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= wr_data;
    end

endmodule : pool_fifo
`default_nettype wire

// File: rtl/systolic_pool_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : systolic_pool_stage                                          |
// | Description : Captures the 2x2 array tile after a settle delay, max-pools  |
// |               it with argmax and queues results behind valid/ready.        |
// |               Define SYSTOLIC_POOL_RELU_EN to clamp negative results to 0. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module systolic_pool_stage
    import systolic_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] result11,
    input  logic [7:0] result12,
    input  logic [7:0] result21,
    input  logic [7:0] result22,
    input  logic       clear_ovf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_idx,
    output logic       busy,
    output logic       overflow,
    output logic       start_err
);

    localparam logic [7:0] c_cnt_last = 8'(SETTLE_CYCLES - 1);

    pool_state_t r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_t11, r_t12, r_t21, r_t22;
    logic [7:0]  r_pool_val;
    logic [1:0]  r_pool_idx;
    logic        r_overflow;
    logic        r_start_err;

    logic [7:0]  w_v11, w_v12, w_v21, w_v22;
    logic        w_lo_sel, w_hi_sel, w_top_sel;
    logic [7:0]  w_lo_val, w_hi_val, w_max_val;
    logic [1:0]  w_lo_idx, w_hi_idx, w_max_idx;
    logic        w_push, w_pop, w_drop;
    logic        w_fifo_full, w_fifo_empty;
    logic [ENTRY_W-1:0] w_fifo_rd;

`ifdef SYSTOLIC_POOL_RELU_EN
    assign w_v11 = relu8(r_t11);
    assign w_v12 = relu8(r_t12);
    assign w_v21 = relu8(r_t21);
    assign w_v22 = relu8(r_t22);
`else
    assign w_v11 = r_t11;
    assign w_v12 = r_t12;
    assign w_v21 = r_t21;
    assign w_v22 = r_t22;
`endif

    // Strict greater-than at every node keeps ties on the lower index.
    assign w_lo_sel  = (w_v12 > w_v11);
    assign w_lo_val  = w_lo_sel ? w_v12 : w_v11;
    assign w_lo_idx  = w_lo_sel ? IDX_12 : IDX_11;
    assign w_hi_sel  = (w_v22 > w_v21);
    assign w_hi_val  = w_hi_sel ? w_v22 : w_v21;
    assign w_hi_idx  = w_hi_sel ? IDX_22 : IDX_21;
    assign w_top_sel = (w_hi_val > w_lo_val);
    assign w_max_val = w_top_sel ? w_hi_val : w_lo_val;
    assign w_max_idx = w_top_sel ? w_hi_idx : w_lo_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_t11      <= '0;
            r_t12      <= '0;
            r_t21      <= '0;
            r_t22      <= '0;
            r_pool_val <= '0;
            r_pool_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == c_cnt_last) begin
                        r_t11   <= result11;
                        r_t12   <= result12;
                        r_t21   <= result21;
                        r_t22   <= result22;
                        r_state <= ST_POOL;
                    end
                end
                ST_POOL: begin
                    r_pool_val <= w_max_val;
                    r_pool_idx <= w_max_idx;
                    r_state    <= ST_PUSH;
                end
                ST_PUSH: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_push = (r_state == ST_PUSH);
    assign w_pop  = !w_fifo_empty && out_ready;
    assign w_drop = w_push && w_fifo_full && !w_pop;

    // A drop in the same cycle as clear_ovf leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            if (w_drop)         r_overflow <= 1'b1;
            else if (clear_ovf) r_overflow <= 1'b0;
            r_start_err <= start && (r_state != ST_IDLE);
        end
    end

    pool_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data ({r_pool_idx, r_pool_val}),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_rd[7:0];
    assign out_idx   = w_fifo_rd[9:8];
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;
    assign start_err = r_start_err;

endmodule : systolic_pool_stage
`default_nettype wire

// File: tb/tb_systolic_pool_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_systolic_pool_stage                                       |
// | Description : Self-checking bench: vector table plus scoreboarded corners. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_systolic_pool_stage;

    localparam int S     = 18;
    localparam int DEPTH = 4;
    localparam int NV    = 9;

    logic       clk = 1'b0;
    logic       rst, start, clear_ovf, out_ready;
    logic [7:0] r11, r12, r21, r22;
    logic       out_valid, busy, overflow, start_err;
    logic [7:0] out_data;
    logic [1:0] out_idx;

    always #5 clk = ~clk;

    systolic_pool_stage #(
        .SETTLE_CYCLES (S),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .result11  (r11),
        .result12  (r12),
        .result21  (r21),
        .result22  (r22),
        .clear_ovf (clear_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .overflow  (overflow),
        .start_err (start_err)
    );

    typedef struct {
        logic [7:0] a, b, c, d;
        logic [7:0] val;
        logic [1:0] idx;
    } vec_t;

    typedef struct {
        logic [7:0] val;
        logic [1:0] idx;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_pops = 0;
    int   pops_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare the head whenever a pop is about to happen.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got data 0x%0h idx %0d, expected no entry", out_data, out_idx);
            end else begin
                mon_e = sb.pop_front();
                check("pop_data", {24'd0, out_data}, {24'd0, mon_e.val});
                check("pop_idx", {30'd0, out_idx}, {30'd0, mon_e.idx});
            end
            n_pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input logic [7:0] a, b, c, d);
        r11 = a; r12 = b; r21 = c; r22 = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] v, input logic [1:0] i);
        exp_t e;
        e.val = v;
        e.idx = i;
        sb.push_back(e);
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'h09, 8'h03, 8'h07, 8'h09, 2'd1};
        vecs[2] = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 2'd0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0};
        vecs[5] = '{8'h10, 8'h20, 8'h20, 8'h10, 8'h20, 2'd1};
        vecs[6] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 2'd2};
        vecs[7] = '{8'h7F, 8'h7E, 8'h7F, 8'h00, 8'h7F, 2'd0};
`ifdef SYSTOLIC_POOL_RELU_EN
        vecs[1] = '{8'h80, 8'h10, 8'hFF, 8'h20, 8'h20, 2'd3};
        vecs[3] = '{8'h80, 8'hFF, 8'h90, 8'hC0, 8'h00, 2'd0};
        vecs[8] = '{8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 2'd0};
`else
        vecs[1] = '{8'h80, 8'h10, 8'hFF, 8'h20, 8'hFF, 2'd2};
        vecs[3] = '{8'h80, 8'hFF, 8'h90, 8'hC0, 8'hFF, 2'd1};
        vecs[8] = '{8'h00, 8'h00, 8'h00, 8'h81, 8'h81, 2'd3};
`endif

        rst = 1'b1; start = 1'b0; clear_ovf = 1'b0; out_ready = 1'b0;
        set_tile(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_out_idx", {30'd0, out_idx}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_start_err", {31'd0, start_err}, 0);
        rst = 1'b0;
        tick();

        // Latency of a single tile and hold while not ready.
        set_tile(8'h05, 8'h09, 8'h03, 8'h07);
        push_exp(8'h09, 2'd1);
        pulse_start();
        check("a_busy_start", {31'd0, busy}, 1);
        repeat (S + 1) tick();
        set_tile(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        check("a_valid_early", {31'd0, out_valid}, 0);
        check("a_busy_push", {31'd0, busy}, 1);
        tick();
        check("a_valid_rise", {31'd0, out_valid}, 1);
        check("a_data", {24'd0, out_data}, 32'h09);
        check("a_idx", {30'd0, out_idx}, 1);
        check("a_busy_done", {31'd0, busy}, 0);
        tick();
        check("a_data_hold", {24'd0, out_data}, 32'h09);
        out_ready = 1'b1;
        tick();
        check("a_valid_popped", {31'd0, out_valid}, 0);

        // Vector table, back-to-back at the maximum tile rate.
        for (int i = 0; i < NV; i++) begin
            set_tile(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            push_exp(vecs[i].val, vecs[i].idx);
            pulse_start();
            check("v_busy_start", {31'd0, busy}, 1);
            repeat (S + 2) tick();
            check("v_valid", {31'd0, out_valid}, 1);
            check("v_busy_done", {31'd0, busy}, 0);
        end
        tick();

        // Overflow: five tiles into a four-entry FIFO with no consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_tile(8'h01, 8'h01, 8'h01, 8'h01);
            case (i % 4)
                0: r11 = 8'h40 + 8'(i);
                1: r12 = 8'h40 + 8'(i);
                2: r21 = 8'h40 + 8'(i);
                default: r22 = 8'h40 + 8'(i);
            endcase
            if (i < 4) push_exp(8'h40 + 8'(i), 2'(i % 4));
            pulse_start();
            repeat (S + 1) tick();
            if (i == 4) clear_ovf = 1'b1;
            tick();
            clear_ovf = 1'b0;
            check("o_overflow", {31'd0, overflow}, (i == 4) ? 1 : 0);
        end
        check("o_head_data", {24'd0, out_data}, 32'h40);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("o_cleared", {31'd0, overflow}, 0);
        set_tile(8'h01, 8'h01, 8'h50, 8'h01);
        push_exp(8'h50, 2'd2);
        pulse_start();
        repeat (S + 1) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("o_simul_no_ovf", {31'd0, overflow}, 0);
        check("o_simul_head", {24'd0, out_data}, 32'h41);
        out_ready = 1'b1;
        repeat (6) tick();
        check("o_drained", {31'd0, out_valid}, 0);

        // start during WAIT and during PUSH is ignored.
        set_tile(8'h11, 8'h22, 8'h33, 8'h44);
        push_exp(8'h44, 2'd3);
        pops_before = n_pops;
        pulse_start();
        repeat (5) tick();
        pulse_start();
        check("e_err_wait", {31'd0, start_err}, 1);
        check("e_busy_wait", {31'd0, busy}, 1);
        tick();
        check("e_err_pulse", {31'd0, start_err}, 0);
        repeat (S - 6) tick();
        check("e_valid_early", {31'd0, out_valid}, 0);
        pulse_start();
        check("e_valid_on_time", {31'd0, out_valid}, 1);
        check("e_err_push", {31'd0, start_err}, 1);
        check("e_busy_push", {31'd0, busy}, 0);
        tick();
        check("e_busy_ignored", {31'd0, busy}, 0);
        check("e_err_clear", {31'd0, start_err}, 0);
        repeat (S + 4) tick();
        check("e_single_result", n_pops - pops_before, 1);
        check("e_no_extra", {31'd0, out_valid}, 0);

        // Reset during POOL with two entries queued.
        out_ready = 1'b0;
        set_tile(8'h01, 8'h02, 8'h03, 8'h04);
        pulse_start();
        repeat (S + 2) tick();
        set_tile(8'h09, 8'h08, 8'h07, 8'h06);
        pulse_start();
        repeat (S + 2) tick();
        pulse_start();
        repeat (S) tick();
        check("r_busy_pool", {31'd0, busy}, 1);
        check("r_queued", {31'd0, out_valid}, 1);
        #2 rst = 1'b1;
        #1;
        check("r_valid_flush", {31'd0, out_valid}, 0);
        check("r_busy_flush", {31'd0, busy}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        out_ready = 1'b1;
        set_tile(8'h30, 8'h60, 8'h10, 8'h20);
        push_exp(8'h60, 2'd1);
        pops_before = n_pops;
        pulse_start();
        repeat (S + 5) tick();
        check("r_one_result", n_pops - pops_before, 1);
        check("r_valid_end", {31'd0, out_valid}, 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_systolic_pool_stage
`default_nettype wire
